// File: rtl/tiny_dnn_pool.sv
// Optional ReLU followed by 2x2/stride-2 max pooling over a channel-major real stream.
// A half-width line buffer carries partial window maxima from the even row to the odd row.
module tiny_dnn_pool #(
   parameter int unsigned MAX_W = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       relu,
   input  logic [3:0] pd,
   input  logic [4:0] ph,
   input  logic [4:0] pw,
   input  logic       s_valid,
   input  real        s_data,
   input  logic       s_last,
   output logic       s_ready,
   output logic       m_valid,
   output real        m_data,
   output logic       m_last,
   input  logic       m_ready,
   output logic       err
);
   localparam int unsigned LB_DEPTH = MAX_W / 2;
   localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t     state_q, state_d;
   logic [4:0] x_q, x_d, y_q, y_d;
   logic [3:0] c_q, c_d;
   logic       relu_q, relu_d;
   logic [3:0] pd_q, pd_d;
   logic [4:0] ph_q, ph_d, pw_q, pw_d;
   logic       m_valid_q, m_valid_d;
   logic       m_last_q, m_last_d;
   logic       err_q, err_d;
   real        m_data_q, m_data_d;

   real              lb_q [LB_DEPTH];
   real              lb_d;
   logic             lb_we;
   logic [LB_AW-1:0] lb_idx;

   logic       accept, cfg_relu, in_win, done_win, at_final, bad, last_win;
   logic [3:0] cfg_pd;
   logic [4:0] cfg_ph, cfg_pw;
   logic [5:0] h2, w2;
   real        v, lb_old, lb_max;

   always_comb begin
      s_ready = ~m_valid_q | m_ready;
      accept  = s_valid & s_ready;

      // The first beat of a sample is processed with the live config it latches.
      cfg_relu = (state_q == IDLE) ? relu : relu_q;
      cfg_pd   = (state_q == IDLE) ? pd   : pd_q;
      cfg_ph   = (state_q == IDLE) ? ph   : ph_q;
      cfg_pw   = (state_q == IDLE) ? pw   : pw_q;

      v = (cfg_relu && !(s_data > 0.0)) ? 0.0 : s_data;

      h2 = ({1'b0, cfg_ph} + 6'd1) & 6'b111110;
      w2 = ({1'b0, cfg_pw} + 6'd1) & 6'b111110;

      in_win   = ({1'b0, x_q} < w2) && ({1'b0, y_q} < h2);
      done_win = x_q[0] & y_q[0];
      lb_idx   = LB_AW'(x_q >> 1);
      lb_old   = lb_q[lb_idx];
      lb_max   = (v > lb_old) ? v : lb_old;

      at_final = (x_q == cfg_pw) && (y_q == cfg_ph) && (c_q == cfg_pd);
      bad      = s_last ^ at_final;
      last_win = (c_q == cfg_pd) && ({1'b0, x_q} == w2 - 6'd1) && ({1'b0, y_q} == h2 - 6'd1);

      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      c_d       = c_q;
      relu_d    = relu_q;
      pd_d      = pd_q;
      ph_d      = ph_q;
      pw_d      = pw_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      m_data_d  = m_data_q;
      err_d     = err_q;
      lb_we     = 1'b0;
      lb_d      = (~x_q[0] & ~y_q[0]) ? v : lb_max;

      if (m_ready) begin
         m_valid_d = 1'b0;
         m_last_d  = 1'b0;
      end

      if (accept) begin
         if (state_q == IDLE) begin
            state_d = RUN;
            relu_d  = relu;
            pd_d    = pd;
            ph_d    = ph;
            pw_d    = pw;
         end

         if (in_win) begin
            if (done_win) begin
               m_valid_d = 1'b1;
               m_data_d  = lb_max;
               m_last_d  = last_win & ~bad;
            end else begin
               lb_we = 1'b1;
            end
         end

         // A misplaced or missing s_last ends the sample at whichever comes first.
         if (s_last || at_final) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
            c_d     = '0;
            err_d   = err_q | bad;
         end else if (x_q == cfg_pw) begin
            x_d = '0;
            if (y_q == cfg_ph) begin
               y_d = '0;
               c_d = c_q + 4'd1;
            end else begin
               y_d = y_q + 5'd1;
            end
         end else begin
            x_d = x_q + 5'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         x_q       <= '0;
         y_q       <= '0;
         c_q       <= '0;
         relu_q    <= 1'b0;
         pd_q      <= '0;
         ph_q      <= '0;
         pw_q      <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_data_q  <= 0.0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         c_q       <= c_d;
         relu_q    <= relu_d;
         pd_q      <= pd_d;
         ph_q      <= ph_d;
         pw_q      <= pw_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
         m_data_q  <= m_data_d;
         err_q     <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (lb_we && !rst) lb_q[lb_idx] <= lb_d;
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_last  = m_last_q;
   assign err     = err_q;

endmodule

// File: tb/tb_tiny_dnn_pool.sv
// Bench for tiny_dnn_pool: directed cases plus randomized back-to-back samples under backpressure,
// checked against a window-level pooling model.
module tb_tiny_dnn_pool;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       relu = 1'b0;
   logic [3:0] pd = '0;
   logic [4:0] ph = '0;
   logic [4:0] pw = '0;
   logic       s_valid = 1'b0;
   real        s_data = 0.0;
   logic       s_last = 1'b0;
   logic       s_ready;
   logic       m_valid;
   real        m_data;
   logic       m_last;
   logic       m_ready = 1'b1;
   logic       err;

   int checks = 0;
   int errors = 0;

   real  vals[$];
   real  exp_data[$];
   logic exp_last[$];
   real  rx_data[$];
   logic rx_last[$];

   bit          bp_random = 1'b0;
   bit          hold_arm = 1'b0;
   int          hold_left = 0;
   int          hold_seen = 0;
   int          hold_bad = 0;
   logic [63:0] hold_val = '0;

   tiny_dnn_pool #(.MAX_W(32)) dut (
      .clk(clk), .rst(rst), .relu(relu), .pd(pd), .ph(ph), .pw(pw),
      .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
      .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
      .err(err)
   );

   always #5 clk = ~clk;

   // Downstream: drives m_ready, tracks forced stalls, collects accepted output beats.
   always @(negedge clk) begin
      if (hold_arm && m_valid) begin
         hold_arm  = 1'b0;
         hold_left = 10;
         hold_val  = $realtobits(m_data);
      end
      if (hold_left > 0) m_ready = 1'b0;
      else if (bp_random) m_ready = 1'($urandom_range(0, 1));
      else m_ready = 1'b1;
      #1;
      if (rst) hold_left = 0;
      if (hold_left > 0) begin
         hold_seen++;
         if (s_ready) hold_bad++;
         if (!m_valid || $realtobits(m_data) !== hold_val) hold_bad++;
         hold_left--;
      end
      if (!rst && m_valid && m_ready) begin
         rx_data.push_back(m_data);
         rx_last.push_back(m_last);
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: each pooled window is the max of its four (ReLU'd) inputs, emitted only
   // if the beat closing it (bottom-right) was accepted before the sample ended.
   task automatic build_expect(input int pd_i, input int ph_i, input int pw_i, input bit relu_i,
                               input int nbeats, input bit clean);
      int hh = ph_i + 1;
      int ww = pw_i + 1;
      int hp = hh / 2;
      int wp = ww / 2;
      for (int c = 0; c <= pd_i; c++)
         for (int oy = 0; oy < hp; oy++)
            for (int ox = 0; ox < wp; ox++) begin
               int  base = c * hh * ww;
               real mx = -1.0e30;
               if (base + (2*oy+1)*ww + 2*ox + 1 < nbeats) begin
                  for (int dy = 0; dy < 2; dy++)
                     for (int dx = 0; dx < 2; dx++) begin
                        real t = vals[base + (2*oy+dy)*ww + 2*ox + dx];
                        if (relu_i && t < 0.0) t = 0.0;
                        if (t > mx) mx = t;
                     end
                  exp_data.push_back(mx);
                  exp_last.push_back(clean && c == pd_i && oy == hp-1 && ox == wp-1);
               end
            end
   endtask

   task automatic send_sample(input int pd_i, input int ph_i, input int pw_i, input bit relu_i,
                              input int n_send, input int last_at);
      for (int i = 0; i < n_send; i++) begin
         bit acc = 1'b0;
         int waitc = 0;
         @(negedge clk);
         if (i == 0) begin
            pd = 4'(pd_i); ph = 5'(ph_i); pw = 5'(pw_i); relu = relu_i;
         end else begin
            pd = 4'($urandom); ph = 5'($urandom); pw = 5'($urandom); relu = 1'($urandom);
         end
         s_valid = 1'b1;
         s_data  = vals[i];
         s_last  = (i == last_at);
         while (!acc) begin
            #1;
            acc = s_ready;
            if (acc) @(posedge clk);
            else begin
               waitc++;
               if (waitc > 200) begin
                  errors++;
                  $display("FAIL send_timeout beat=%0d observed=stalled required=accept", i);
                  $display("CHECKS %0d ERRORS %0d", checks, errors);
                  $fatal(1, "input stalled");
               end
               @(negedge clk);
            end
         end
      end
   endtask

   task automatic go_idle();
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic fill_ramp(input int n);
      vals.delete();
      for (int i = 0; i < n; i++) vals.push_back(real'(i));
   endtask

   task automatic run_clean(input int pd_i, input int ph_i, input int pw_i, input bit relu_i);
      int n = (pd_i + 1) * (ph_i + 1) * (pw_i + 1);
      build_expect(pd_i, ph_i, pw_i, relu_i, n, 1'b1);
      send_sample(pd_i, ph_i, pw_i, relu_i, n, n - 1);
   endtask

   task automatic check_stream(input string tag);
      int waitc = 0;
      int n;
      while (rx_data.size() < exp_data.size() && waitc < 300) begin
         @(negedge clk);
         waitc++;
      end
      repeat (4) @(negedge clk);
      #2;
      chk({tag, "_count"}, 64'(rx_data.size()), 64'(exp_data.size()));
      n = (rx_data.size() < exp_data.size()) ? rx_data.size() : exp_data.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_data%0d", tag, i), $realtobits(rx_data[i]), $realtobits(exp_data[i]));
         chk($sformatf("%s_last%0d", tag, i), 64'(rx_last[i]), 64'(exp_last[i]));
      end
      rx_data.delete(); rx_last.delete(); exp_data.delete(); exp_last.delete();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      chk("rst_m_valid", 64'(m_valid), 64'(0));
      chk("rst_m_last", 64'(m_last), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_m_data", $realtobits(m_data), $realtobits(0.0));
      chk("rst_s_ready", 64'(s_ready), 64'(1));
      @(negedge clk);
      rst = 1'b0;

      fill_ramp(16);
      run_clean(0, 3, 3, 1'b0);
      go_idle();
      check_stream("p4x4");
      chk("p4x4_err", 64'(err), 64'(0));

      vals.delete();
      vals = '{-1.0, -2.0, -3.0, -4.0, 1.0, 2.0, 3.0, 4.0};
      run_clean(1, 1, 1, 1'b1);
      run_clean(1, 1, 1, 1'b0);
      go_idle();
      check_stream("p2x2x2");

      fill_ramp(25);
      run_clean(0, 4, 4, 1'b0);
      go_idle();
      check_stream("p5x5");
      chk("p5x5_err", 64'(err), 64'(0));

      hold_seen = 0; hold_bad = 0; hold_arm = 1'b1;
      fill_ramp(16);
      run_clean(0, 3, 3, 1'b0);
      go_idle();
      check_stream("hold");
      chk("hold_cycles", 64'(hold_seen), 64'(10));
      chk("hold_stable", 64'(hold_bad), 64'(0));
      chk("hold_value", hold_val, $realtobits(5.0));

      fill_ramp(16);
      build_expect(0, 3, 3, 1'b0, 10, 1'b0);
      send_sample(0, 3, 3, 1'b0, 10, 9);
      go_idle();
      check_stream("early");
      chk("early_err", 64'(err), 64'(1));
      run_clean(0, 3, 3, 1'b0);
      go_idle();
      check_stream("after_early");
      chk("err_sticky", 64'(err), 64'(1));

      fill_ramp(16);
      send_sample(0, 3, 3, 1'b0, 6, -1);
      @(negedge clk);
      rst = 1'b1; s_valid = 1'b1; s_data = vals[6]; s_last = 1'b0;
      #1;
      chk("pre_rst_pending", 64'(m_valid), 64'(1));
      @(negedge clk);
      rst = 1'b0; s_valid = 1'b0;
      #1;
      chk("midrst_m_valid", 64'(m_valid), 64'(0));
      chk("midrst_m_last", 64'(m_last), 64'(0));
      chk("midrst_err", 64'(err), 64'(0));
      rx_data.delete(); rx_last.delete(); exp_data.delete(); exp_last.delete();
      run_clean(0, 3, 3, 1'b0);
      go_idle();
      check_stream("after_rst");

      bp_random = 1'b1;
      for (int s = 0; s < 8; s++) begin
         int  pdr = $urandom_range(0, 2);
         int  phr = $urandom_range(0, 5);
         int  pwr = $urandom_range(0, 7);
         bit  rl  = 1'($urandom_range(0, 1));
         int  n   = (pdr + 1) * (phr + 1) * (pwr + 1);
         vals.delete();
         for (int i = 0; i < n; i++) vals.push_back(real'(int'($urandom_range(0, 64)) - 32) / 2.0);
         run_clean(pdr, phr, pwr, rl);
      end
      go_idle();
      check_stream("rand");
      chk("rand_err", 64'(err), 64'(0));
      bp_random = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
